// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage.
// Owns the PC register, drives the instruction-memory request/ready
// handshake and owns the IF/ID pipeline register. A small FSM tracks
// whether a fetch is live (S_FETCH), a fetch is outstanding but already
// known to be wrong-path (S_KILL), or a completed word is parked while
// decode is stalled (S_HOLD).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,          // active-low, asynchronous
  input  logic [31:0] i_pcnext,
  input  logic        i_if_flush,
  input  logic        i_pc_write,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc_plus4,
  output logic        o_ifid_valid,
  output logic        o_fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request live at r_pc, result will be used
    S_KILL  = 2'd1,  // request live at r_pc, result will be dropped
    S_HOLD  = 2'd2   // word already fetched, waiting for decode
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redirect;     // target to jump to once a killed fetch drains
  logic [31:0] r_buf_instr;    // parked word while decode is stalled
  logic [31:0] r_buf_pc_plus4;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;

  logic [31:0] w_pc_plus4;
  logic        w_req;

  // pc+4 wraps naturally at 32 bits; also feeds the next-PC mux
  assign w_pc_plus4 = r_pc + 32'd4;

  // A request is outstanding in every state except while a word is parked
  assign w_req = (r_state != S_HOLD);

  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_imem_req      = w_req;
  assign o_imem_addr     = r_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc_plus4 = r_ifid_pc_plus4;
  assign o_ifid_valid    = r_ifid_valid;
  assign o_fetch_busy    = w_req & ~i_imem_ready;

  // Fetch FSM, PC, redirect/holding registers and IF/ID register.
  // Priority in every state: flush, then stall (pc_write=0), then advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_redirect      <= 32'h0;
      r_buf_instr     <= 32'h0;
      r_buf_pc_plus4  <= 32'h0;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= 32'h0;
      r_ifid_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_imem_ready) begin
            if (i_if_flush) begin
              // wrong-path word: drop it and redirect right away
              r_pc            <= i_pcnext;
              r_ifid_instr    <= NOP_INSTR;
              r_ifid_pc_plus4 <= 32'h0;
              r_ifid_valid    <= 1'b0;
            end else if (i_pc_write) begin
              r_pc            <= i_pcnext;
              r_ifid_instr    <= i_imem_rdata;
              r_ifid_pc_plus4 <= w_pc_plus4;
              r_ifid_valid    <= 1'b1;
            end else begin
              // decode stalled: park the word so memory is not re-read
              r_buf_instr    <= i_imem_rdata;
              r_buf_pc_plus4 <= w_pc_plus4;
              r_state        <= S_HOLD;
            end
          end else begin
            if (i_if_flush) begin
              // cannot drop the address mid-request; remember the target
              r_redirect      <= i_pcnext;
              r_ifid_instr    <= NOP_INSTR;
              r_ifid_pc_plus4 <= 32'h0;
              r_ifid_valid    <= 1'b0;
              r_state         <= S_KILL;
            end else if (i_pc_write) begin
              // memory wait: feed decode a bubble
              r_ifid_instr    <= NOP_INSTR;
              r_ifid_pc_plus4 <= 32'h0;
              r_ifid_valid    <= 1'b0;
            end
          end
        end

        S_KILL: begin
          if (i_if_flush) begin
            r_redirect <= i_pcnext;
          end
          if (i_if_flush || i_pc_write) begin
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= 32'h0;
            r_ifid_valid    <= 1'b0;
          end
          if (i_imem_ready) begin
            // a flush arriving in the same cycle is the newest target
            r_pc    <= i_if_flush ? i_pcnext : r_redirect;
            r_state <= S_FETCH;
          end
        end

        S_HOLD: begin
          if (i_if_flush) begin
            r_pc            <= i_pcnext;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= 32'h0;
            r_ifid_valid    <= 1'b0;
            r_state         <= S_FETCH;
          end else if (i_pc_write) begin
            r_pc            <= i_pcnext;
            r_ifid_instr    <= r_buf_instr;
            r_ifid_pc_plus4 <= r_buf_pc_plus4;
            r_ifid_valid    <= 1'b1;
            r_state         <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
